quote_spread: RTL and testbench

QUOTE_SPREAD -- requirements
Module: quote_spread

---
 rtl/quote_spread.sv | 142 ++++++++++++++
 tb/tb_quote_spread.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/quote_spread.sv
// Three-stage market-making quote pipeline: turns a reservation price into bid/ask quotes
// around it using spread = max(gamma*sigma^2*(T-t) + liquidity_term, min_spread).
module quote_spread #(
  parameter int unsigned FP_WORD_SIZE = 64,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FRAC_BITS    = 32
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic signed [FP_WORD_SIZE-1:0] i_ref_price,
  input  logic signed [FP_WORD_SIZE-1:0] i_volatility,
  input  logic signed [FP_WORD_SIZE-1:0] i_risk_factor,
  input  logic        [DATA_WIDTH-1:0]   i_curr_time,
  input  logic        [DATA_WIDTH-1:0]   i_terminal_time,
  input  logic signed [FP_WORD_SIZE-1:0] i_liquidity_term,
  input  logic signed [FP_WORD_SIZE-1:0] i_min_spread,
  input  logic                           i_data_valid,
  output logic                           o_ready,
  input  logic                           i_ready,
  output logic signed [FP_WORD_SIZE-1:0] o_bid_price,
  output logic signed [FP_WORD_SIZE-1:0] o_ask_price,
  output logic signed [FP_WORD_SIZE-1:0] o_spread,
  output logic                           o_data_valid
);

  localparam int unsigned PW = 2 * FP_WORD_SIZE;
  localparam int unsigned VW = FP_WORD_SIZE + DATA_WIDTH + 1;
  localparam int unsigned SW = FP_WORD_SIZE + 1;
  localparam logic signed [FP_WORD_SIZE-1:0] MaxPos = {1'b0, {(FP_WORD_SIZE-1){1'b1}}};
  localparam logic signed [FP_WORD_SIZE-1:0] MinNeg = {1'b1, {(FP_WORD_SIZE-1){1'b0}}};

  // Collapse a one-bit-wider sum/difference back to word width, saturating on overflow.
  function automatic logic signed [FP_WORD_SIZE-1:0] sat_sum(input logic signed [SW-1:0] v);
    if (v[SW-1] != v[SW-2]) return v[SW-1] ? MinNeg : MaxPos;
    return v[SW-2:0];
  endfunction

  // Stage registers
  logic                           s1_valid, s2_valid, s3_valid;
  logic        [DATA_WIDTH-1:0]   s1_tau;
  logic signed [FP_WORD_SIZE-1:0] s1_gs, s1_ref, s1_liq, s1_min;
  logic signed [FP_WORD_SIZE-1:0] s2_ref, s2_spread;

  // Handshake: a stage may load when it is empty or its content moves on this cycle
  logic s1_load, s2_load, s3_load;
  assign s3_load      = !s3_valid || i_ready;
  assign s2_load      = !s2_valid || s3_load;
  assign s1_load      = !s1_valid || s2_load;
  assign o_ready      = s1_load;
  assign o_data_valid = s3_valid;

  // S1 datapath: time to horizon and gamma*sigma^2 rescaled to Q32.32
  logic signed [PW-1:0]           gs_prod, gs_shift;
  logic                           gs_ovf;
  logic signed [FP_WORD_SIZE-1:0] gs_next;
  logic        [DATA_WIDTH-1:0]   tau_next;
  always_comb begin
    gs_prod  = PW'(i_risk_factor) * PW'(i_volatility);
    gs_shift = gs_prod >>> FRAC_BITS;
    // Upper bits from the Q-point's sign bit upward must all agree to fit in one word
    gs_ovf   = !((&gs_shift[PW-1:FP_WORD_SIZE-1]) || !(|gs_shift[PW-1:FP_WORD_SIZE-1]));
    gs_next  = gs_ovf ? MaxPos : gs_shift[FP_WORD_SIZE-1:0];
    tau_next = (i_terminal_time > i_curr_time) ? (i_terminal_time - i_curr_time) : '0;
  end

  // S2 datapath: variance term, liquidity term, spread floor
  logic signed [VW-1:0]           var_prod;
  logic                           var_ovf;
  logic signed [FP_WORD_SIZE-1:0] var_term, raw, spread_next;
  logic signed [SW-1:0]           raw_sum;
  always_comb begin
    var_prod    = VW'(s1_gs) * VW'($signed({1'b0, s1_tau}));
    var_ovf     = !((&var_prod[VW-1:FP_WORD_SIZE-1]) || !(|var_prod[VW-1:FP_WORD_SIZE-1]));
    var_term    = var_ovf ? MaxPos : var_prod[FP_WORD_SIZE-1:0];
    raw_sum     = SW'(var_term) + SW'(s1_liq);
    raw         = sat_sum(raw_sum);
    spread_next = (raw > s1_min) ? raw : s1_min;
  end

  // S3 datapath: split spread symmetrically around the reference; bid never goes negative
  logic signed [FP_WORD_SIZE-1:0] half, ask_next, bid_sat, bid_next;
  always_comb begin
    half     = s2_spread >>> 1;
    ask_next = sat_sum(SW'(s2_ref) + SW'(half));
    bid_sat  = sat_sum(SW'(s2_ref) - SW'(half));
    bid_next = bid_sat[FP_WORD_SIZE-1] ? '0 : bid_sat;
  end

  // S1 register: capture accepted input along with its per-word parameters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_tau   <= '0;
      s1_gs    <= '0;
      s1_ref   <= '0;
      s1_liq   <= '0;
      s1_min   <= '0;
    end else if (s1_load) begin
      s1_valid <= i_data_valid;
      if (i_data_valid) begin
        s1_tau <= tau_next;
        s1_gs  <= gs_next;
        s1_ref <= i_ref_price;
        s1_liq <= i_liquidity_term;
        s1_min <= i_min_spread;
      end
    end
  end

  // S2 register: spread and carried reference price
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_valid  <= 1'b0;
      s2_ref    <= '0;
      s2_spread <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ref    <= s1_ref;
        s2_spread <= spread_next;
      end
    end
  end

  // S3 register: output quotes, held while downstream stalls
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s3_valid    <= 1'b0;
      o_bid_price <= '0;
      o_ask_price <= '0;
      o_spread    <= '0;
    end else if (s3_load) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        o_bid_price <= bid_next;
        o_ask_price <= ask_next;
        o_spread    <= s2_spread;
      end
    end
  end

endmodule

// File: tb/tb_quote_spread.sv
// Directed self-checking bench for quote_spread.
module tb_quote_spread;

  localparam logic signed [63:0] Max   = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] Half  = 64'h0000_0000_8000_0000;
  localparam logic signed [63:0] Quart = 64'h0000_0000_4000_0000;
  localparam logic signed [63:0] One   = 64'h0000_0001_0000_0000;
  localparam logic signed [63:0] Two   = 64'h0000_0002_0000_0000;
  localparam logic signed [63:0] Three = 64'h0000_0003_0000_0000;
  localparam logic signed [63:0] P100  = 64'h0000_0064_0000_0000;

  logic               i_clk, i_reset, i_data_valid, i_ready, o_ready, o_data_valid;
  logic signed [63:0] i_ref_price, i_volatility, i_risk_factor, i_liquidity_term, i_min_spread;
  logic        [31:0] i_curr_time, i_terminal_time;
  logic signed [63:0] o_bid_price, o_ask_price, o_spread;

  int checks   = 0;
  int failures = 0;

  quote_spread dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_ref_price     (i_ref_price),
    .i_volatility    (i_volatility),
    .i_risk_factor   (i_risk_factor),
    .i_curr_time     (i_curr_time),
    .i_terminal_time (i_terminal_time),
    .i_liquidity_term(i_liquidity_term),
    .i_min_spread    (i_min_spread),
    .i_data_valid    (i_data_valid),
    .o_ready         (o_ready),
    .i_ready         (i_ready),
    .o_bid_price     (o_bid_price),
    .o_ask_price     (o_ask_price),
    .o_spread        (o_spread),
    .o_data_valid    (o_data_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic set_word(input logic signed [63:0] r, input logic signed [63:0] g,
                          input logic signed [63:0] s, input logic [31:0] t,
                          input logic [31:0] tt, input logic signed [63:0] l,
                          input logic signed [63:0] m);
    i_ref_price = r; i_risk_factor = g; i_volatility = s;
    i_curr_time = t; i_terminal_time = tt; i_liquidity_term = l; i_min_spread = m;
  endtask

  // Present one word, scramble the per-word inputs after acceptance, stop where it should emerge.
  task automatic send_one(input logic signed [63:0] r, input logic signed [63:0] g,
                          input logic signed [63:0] s, input logic [31:0] t,
                          input logic [31:0] tt, input logic signed [63:0] l,
                          input logic signed [63:0] m);
    @(negedge i_clk);
    set_word(r, g, s, t, tt, l, m);
    i_data_valid = 1'b1; i_ready = 1'b1;
    @(negedge i_clk);
    i_data_valid = 1'b0;
    set_word(64'h0000_007B_0000_0000, One, One, 0, 5, 64'h0000_0007_0000_0000,
             64'h0000_0032_0000_0000);
    @(negedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b1; i_data_valid = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (o_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_data_valid); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++; if (o_bid_price !== 64'sd0) begin failures++; $display("FAIL reset_bid got=%h exp=0", o_bid_price); end
    checks++; if (o_ask_price !== 64'sd0) begin failures++; $display("FAIL reset_ask got=%h exp=0", o_ask_price); end
    checks++; if (o_spread !== 64'sd0) begin failures++; $display("FAIL reset_spread got=%h exp=0", o_spread); end
  endtask

  // 0.5*0.25*8 + 0.5 = 1.5; bid 99.25, ask 100.75; also checks 3-cycle latency and no repeat.
  task automatic test_basic();
    @(negedge i_clk);
    set_word(P100, Half, Quart, 2, 10, Half, 64'sd0);
    i_data_valid = 1'b1; i_ready = 1'b1;
    @(negedge i_clk);
    i_data_valid = 1'b0;
    set_word(64'h0000_007B_0000_0000, One, One, 0, 5, 64'h0000_0007_0000_0000,
             64'h0000_0032_0000_0000);
    checks++; if (o_data_valid !== 1'b0) begin failures++; $display("FAIL basic_lat1 got=%b exp=0", o_data_valid); end
    @(negedge i_clk);
    checks++; if (o_data_valid !== 1'b0) begin failures++; $display("FAIL basic_lat2 got=%b exp=0", o_data_valid); end
    @(negedge i_clk);
    checks++; if (o_data_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", o_data_valid); end
    checks++; if (o_spread !== 64'h0000_0001_8000_0000) begin failures++; $display("FAIL basic_spread got=%h exp=%h", o_spread, 64'h0000_0001_8000_0000); end
    checks++; if (o_bid_price !== 64'h0000_0063_4000_0000) begin failures++; $display("FAIL basic_bid got=%h exp=%h", o_bid_price, 64'h0000_0063_4000_0000); end
    checks++; if (o_ask_price !== 64'h0000_0064_C000_0000) begin failures++; $display("FAIL basic_ask got=%h exp=%h", o_ask_price, 64'h0000_0064_C000_0000); end
    @(negedge i_clk);
    checks++; if (o_data_valid !== 1'b0) begin failures++; $display("FAIL basic_once got=%b exp=0", o_data_valid); end
  endtask

  // t past T gives tau=0; raw 0.5 lifted to the 2.0 floor.
  task automatic test_floor();
    send_one(P100, Half, Quart, 12, 10, Half, Two);
    checks++; if (o_data_valid !== 1'b1) begin failures++; $display("FAIL floor_valid got=%b exp=1", o_data_valid); end
    checks++; if (o_spread !== Two) begin failures++; $display("FAIL floor_spread got=%h exp=%h", o_spread, Two); end
    checks++; if (o_bid_price !== 64'h0000_0063_0000_0000) begin failures++; $display("FAIL floor_bid got=%h exp=%h", o_bid_price, 64'h0000_0063_0000_0000); end
    checks++; if (o_ask_price !== 64'h0000_0065_0000_0000) begin failures++; $display("FAIL floor_ask got=%h exp=%h", o_ask_price, 64'h0000_0065_0000_0000); end
  endtask

  // ref 0.5 with spread 3.0: bid would be -1.0, clamps to 0; ask 2.0.
  task automatic test_bid_clamp();
    send_one(Half, 64'sd0, Quart, 0, 50, Three, 64'sd0);
    checks++; if (o_spread !== Three) begin failures++; $display("FAIL clamp_spread got=%h exp=%h", o_spread, Three); end
    checks++; if (o_bid_price !== 64'sd0) begin failures++; $display("FAIL clamp_bid got=%h exp=0", o_bid_price); end
    checks++; if (o_ask_price !== Two) begin failures++; $display("FAIL clamp_ask got=%h exp=%h", o_ask_price, Two); end
  endtask

  task automatic test_saturation();
    // gamma*sigma^2 overflows; ref large enough that ask also overflows.
    send_one(64'h5000_0000_0000_0000, Max, Max, 0, 1000, Half, 64'sd0);
    checks++; if (o_spread !== Max) begin failures++; $display("FAIL sat_spread got=%h exp=%h", o_spread, Max); end
    checks++; if (o_ask_price !== Max) begin failures++; $display("FAIL sat_ask got=%h exp=%h", o_ask_price, Max); end
    checks++; if (o_bid_price !== 64'h1000_0000_0000_0001) begin failures++; $display("FAIL sat_bid got=%h exp=%h", o_bid_price, 64'h1000_0000_0000_0001); end
    // Same overflow with ref 100.0: ask = 100.0 + 0x3FFF..F, bid clamps.
    send_one(P100, Max, Max, 0, 1000, Half, 64'sd0);
    checks++; if (o_ask_price !== 64'h4000_0063_FFFF_FFFF) begin failures++; $display("FAIL sat_ask100 got=%h exp=%h", o_ask_price, 64'h4000_0063_FFFF_FFFF); end
    checks++; if (o_bid_price !== 64'sd0) begin failures++; $display("FAIL sat_bid100 got=%h exp=0", o_bid_price); end
    // gs = 2^20 fits, but times tau = 2^32-1 overflows the variance term.
    send_one(64'sd0, 64'h0010_0000_0000_0000, One, 0, 32'hFFFF_FFFF, Half, 64'sd0);
    checks++; if (o_spread !== Max) begin failures++; $display("FAIL vsat_spread got=%h exp=%h", o_spread, Max); end
    checks++; if (o_ask_price !== 64'h3FFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL vsat_ask got=%h exp=%h", o_ask_price, 64'h3FFF_FFFF_FFFF_FFFF); end
  endtask

  // Word k: ref=(20+k).0, liq=2(k+1).0, gamma=0 -> spread 2(k+1), bid 19.0, ask (21+2k).0.
  task automatic test_back_to_back();
    int idx_in = 0;
    int idx_out = 0;
    logic signed [63:0] e_spread, e_bid, e_ask;
    for (int cyc = 0; cyc < 40 && idx_out < 8; cyc++) begin
      @(negedge i_clk);
      i_ready = !(cyc >= 4 && cyc < 8);
      if (idx_in < 8) begin
        set_word(64'(20 + idx_in) <<< 32, 64'sd0, Quart, 0, 9, 64'(2 * (idx_in + 1)) <<< 32,
                 64'sd0);
        i_data_valid = 1'b1;
      end else begin
        i_data_valid = 1'b0;
      end
      #1;
      if (o_data_valid) begin
        e_spread = 64'(2 * (idx_out + 1)) <<< 32;
        e_bid    = 64'sd19 <<< 32;
        e_ask    = 64'(21 + 2 * idx_out) <<< 32;
        checks++; if (o_spread !== e_spread) begin failures++; $display("FAIL b2b_spread word=%0d got=%h exp=%h", idx_out, o_spread, e_spread); end
        checks++; if (o_bid_price !== e_bid) begin failures++; $display("FAIL b2b_bid word=%0d got=%h exp=%h", idx_out, o_bid_price, e_bid); end
        checks++; if (o_ask_price !== e_ask) begin failures++; $display("FAIL b2b_ask word=%0d got=%h exp=%h", idx_out, o_ask_price, e_ask); end
        if (i_ready) idx_out++;
      end
      if (!i_ready) begin
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready cyc=%0d got=%b exp=0", cyc, o_ready); end
        checks++; if (o_data_valid !== 1'b1) begin failures++; $display("FAIL b2b_stall_valid cyc=%0d got=%b exp=1", cyc, o_data_valid); end
      end
      if (o_ready && idx_in < 8) idx_in++;
    end
    checks++; if (idx_out != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", idx_out); end
    @(negedge i_clk);
    i_data_valid = 1'b0;
    #1;
    checks++; if (o_data_valid !== 1'b0) begin failures++; $display("FAIL b2b_extra got=%b exp=0", o_data_valid); end
  endtask

  task automatic test_reset_inflight();
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      set_word(P100, Half, Quart, 2, 10, Half, 64'sd0);
      i_data_valid = 1'b1; i_ready = 1'b1;
    end
    @(negedge i_clk);
    checks++; if (o_data_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", o_data_valid); end
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0; i_data_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (o_data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid cyc=%0d got=%b exp=0", k, o_data_valid); end
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready cyc=%0d got=%b exp=1", k, o_ready); end
      checks++; if ((o_bid_price | o_ask_price | o_spread) !== 64'sd0) begin failures++; $display("FAIL rst_data cyc=%0d got=%h/%h/%h exp=0", k, o_bid_price, o_ask_price, o_spread); end
      @(negedge i_clk);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_data_valid = 1'b0; i_ready = 1'b1;
    set_word(64'sd0, 64'sd0, 64'sd0, 0, 0, 64'sd0, 64'sd0);
    test_reset();
    test_basic();
    test_floor();
    test_bid_clamp();
    test_saturation();
    test_back_to_back();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
